// File: rtl/risc_ctrl_if.sv
// Signal bundle between the instruction-sequencing controller and the CPU datapath.
// The controller is the master: it consumes IR/flag/ready and drives all strobes.
interface risc_ctrl_if;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       ac_src;
    logic [2:0] alu_op;
    logic       wr;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero, mem_ready,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, ac_src, alu_op, wr, data_e, halt, phase
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, ac_src, alu_op, wr, data_e, halt, phase
    );
endinterface

// File: rtl/risc_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
//
// state        | meaning
// S_INST_ADDR  | 0: PC drives memory address
// S_INST_FETCH | 1: read instruction, wait for mem_ready
// S_INST_LOAD  | 2: load IR
// S_IDLE       | 3: IR valid, settle
// S_OP_ADDR    | 4: operand address, PC increment or halt
// S_OP_FETCH   | 5: operand read, waits for mem_ready on ALU-type ops
// S_ALU_OP     | 6: skip / jump / present store data
// S_STORE      | 7: accumulator load, memory write, jump
// S_HALTED     | sticky halt, left only by reset
module risc_controller (
    input  logic clk,
    input  logic rst_n,
    risc_ctrl_if.master bus
);
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t state, next_state;
    logic   is_aluop;

    assign is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                      (bus.opcode == OP_AND) || (bus.opcode == OP_LDA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INST_ADDR;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        bus.sel     = 1'b0;
        bus.rd      = 1'b0;
        bus.ld_ir   = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.ld_pc   = 1'b0;
        bus.ld_ac   = 1'b0;
        bus.wr      = 1'b0;
        bus.data_e  = 1'b0;
        bus.halt    = 1'b0;
        bus.ac_src  = (bus.opcode == OP_LDA);
        bus.phase   = (state == S_HALTED) ? 3'd4 : state[2:0];
        case (bus.opcode)
            OP_SUB:  bus.alu_op = 3'b001;
            OP_AND:  bus.alu_op = 3'b010;
            default: bus.alu_op = 3'b000;
        endcase

        case (state)
            S_INST_ADDR: begin
                bus.sel    = 1'b1;
                next_state = S_INST_FETCH;
            end
            S_INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
                if (bus.mem_ready) next_state = S_INST_LOAD;
            end
            S_INST_LOAD: begin
                bus.sel    = 1'b1;
                bus.rd     = 1'b1;
                bus.ld_ir  = 1'b1;
                next_state = S_IDLE;
            end
            S_IDLE: begin
                bus.sel    = 1'b1;
                bus.rd     = 1'b1;
                next_state = S_OP_ADDR;
            end
            S_OP_ADDR: begin
                if (bus.opcode == OP_HLT) begin
                    bus.halt   = 1'b1;
                    next_state = S_HALTED;
                end else begin
                    bus.inc_pc = 1'b1;
                    next_state = S_OP_FETCH;
                end
            end
            S_OP_FETCH: begin
                bus.rd = is_aluop;
                // only operand reads stall; SKZ/STO/JMP never touch read data
                if (!is_aluop || bus.mem_ready) next_state = S_ALU_OP;
            end
            S_ALU_OP: begin
                bus.rd     = is_aluop;
                bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                bus.ld_pc  = (bus.opcode == OP_JMP);
                bus.data_e = (bus.opcode == OP_STO);
                next_state = S_STORE;
            end
            S_STORE: begin
                bus.rd     = is_aluop;
                bus.ld_ac  = is_aluop;
                bus.ld_pc  = (bus.opcode == OP_JMP);
                bus.wr     = (bus.opcode == OP_STO);
                bus.data_e = (bus.opcode == OP_STO);
                next_state = S_INST_ADDR;
            end
            S_HALTED: begin
                bus.halt = 1'b1;
            end
            default: next_state = S_INST_ADDR;
        endcase
    end
endmodule
